// File: rtl/ss_sprite_fetch_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the spaceship sprite fetch controller.
package ss_pkg;
  localparam int SPR_W    = 75;
  localparam int SPR_H    = 75;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;
  localparam int NPIX     = SPR_W * SPR_H;
  localparam int CNT_W    = 13;
  localparam logic [2:0] TRANSPARENT = 3'b000;

  typedef enum logic [1:0] {IDLE, ARMED, DRAW, DONE} ss_state_t;
  typedef logic [3:0] ss_angle_t;

  // Keeps the whole sprite box on screen.
  function automatic logic [9:0] clamp10(input logic [9:0] val, input logic [9:0] lim);
    return (val > lim) ? lim : val;
  endfunction
endpackage

// File: rtl/ss_sprite_fetch_ctrl_if.sv
// Timing-generator, sprite-ROM and pixel-mixer signals of the sprite fetch controller.
interface ss_sprite_fetch_ctrl_if;
  import ss_pkg::*;

  logic              frame_start;
  logic              de;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic [9:0]        ss_x;
  logic [9:0]        ss_y;
  ss_angle_t         angle_req;
  logic [2:0]        rom_pixel;
  ss_angle_t         rom_angle;
  logic [ADDR_W-1:0] rom_addr;
  logic              pix_valid;
  logic              pix_opaque;
  logic [2:0]        pix_color;

  modport slave (
    input  frame_start, de, hcount, vcount, ss_x, ss_y, angle_req, rom_pixel,
    output rom_angle, rom_addr, pix_valid, pix_opaque, pix_color
  );

  modport master (
    output frame_start, de, hcount, vcount, ss_x, ss_y, angle_req, rom_pixel,
    input  rom_angle, rom_addr, pix_valid, pix_opaque, pix_color
  );
endinterface

// File: rtl/ss_valid_pipe.sv
// N-stage valid shift register; o_tap is the stage aligned with registered ROM data.
module ss_valid_pipe #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic o_tap,
  output logic o_valid
);
  logic [N-1:0] r_stages;

  always_ff @(posedge clk) begin
    if (!rst_n) r_stages <= '0;
    else        r_stages <= {r_stages[N-2:0], i_valid};
  end

  assign o_tap   = r_stages[N-2];
  assign o_valid = r_stages[N-1];
endmodule

// File: rtl/ss_sprite_fetch_ctrl.sv
// Per-frame sprite ROM read sequencer: latches position/angle on frame_start and
// streams raster-order addresses inside the sprite box; colour returns 3 cycles later.
//   state | meaning
//   IDLE  | after reset, nothing drawn until frame_start
//   ARMED | position latched, waiting for first in-box pixel
//   DRAW  | issuing one address per in-box pixel
//   DONE  | full sprite issued, quiet until next frame_start
module ss_sprite_fetch_ctrl
  import ss_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  ss_sprite_fetch_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NPIX - 1);

  ss_state_t        r_state, w_next;
  logic [9:0]       r_x_l, r_y_l;
  ss_angle_t        r_angle;
  logic [CNT_W-1:0] r_cnt, r_addr;
  logic [2:0]       r_color;
  logic             r_opaque;
  logic [10:0]      w_x_end, w_y_end;
  logic             w_in_box, w_hit, w_last, w_tap, w_valid;

  assign w_x_end  = {1'b0, r_x_l} + 11'(SPR_W - 1);
  assign w_y_end  = {1'b0, r_y_l} + 11'(SPR_H - 1);
  assign w_in_box = bus.de && !bus.frame_start &&
                    (bus.hcount >= r_x_l) && ({1'b0, bus.hcount} <= w_x_end) &&
                    (bus.vcount >= r_y_l) && ({1'b0, bus.vcount} <= w_y_end);
  assign w_hit    = w_in_box && ((r_state == ARMED) || (r_state == DRAW));
  assign w_last   = (r_cnt == LAST_ADDR);

  always_comb begin
    w_next = r_state;
    if (bus.frame_start) begin
      w_next = ARMED;
    end else begin
      case (r_state)
        ARMED:   if (w_hit) w_next = w_last ? DONE : DRAW;
        DRAW:    if (w_hit && w_last) w_next = DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_x_l    <= '0;
      r_y_l    <= '0;
      r_angle  <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_color  <= '0;
      r_opaque <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.frame_start) begin
        r_x_l   <= clamp10(bus.ss_x, 10'(H_ACTIVE - SPR_W));
        r_y_l   <= clamp10(bus.ss_y, 10'(V_ACTIVE - SPR_H));
        r_angle <= bus.angle_req;
        r_cnt   <= '0;
      end else if (w_hit) begin
        r_addr <= r_cnt;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
      // Output stage: ROM data is only trusted where the valid pipe says so.
      r_color  <= w_tap ? bus.rom_pixel : 3'b000;
      r_opaque <= w_tap && (bus.rom_pixel != TRANSPARENT);
    end
  end

  ss_valid_pipe #(.N(3)) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_hit),
    .o_tap   (w_tap),
    .o_valid (w_valid)
  );

  assign bus.rom_angle  = r_angle;
  assign bus.rom_addr   = ADDR_W'(r_addr);
  assign bus.pix_valid  = w_valid;
  assign bus.pix_opaque = r_opaque;
  assign bus.pix_color  = r_color;
endmodule
